// File: rtl/start_screen_overlay_pkg.sv
// Shared constants and types for the title-screen overlay.
// Holds the glyph placement table, the default glyph size and the selector FSM states.
package start_screen_overlay_pkg;

    localparam int NUM_GLYPHS_DEF = 9;
    localparam int GLYPH_W_DEF    = 30;
    localparam int GLYPH_H_DEF    = 45;

    // Title glyphs first, then the player-1 prompt and the player-2 prompt.
    localparam int GLYPH_X [NUM_GLYPHS_DEF] = '{200, 230, 290, 320, 350, 380, 410, 260, 350};
    localparam int GLYPH_Y [NUM_GLYPHS_DEF] = '{165, 165, 165, 165, 165, 165, 165, 270, 270};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_CONFIRM = 2'd2
    } state_e;

endpackage

// File: rtl/start_screen_overlay_glyph_hit.sv
// Single-glyph bounds test and in-glyph sprite ROM offset.
// The bounds are half-open; the address is only meaningful while hit is high.
module glyph_hit #(
    parameter int X0      = 0,
    parameter int Y0      = 0,
    parameter int GLYPH_W = 30,
    parameter int GLYPH_H = 45,
    parameter int ADDR_W  = 19
) (
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);

    // The 11-bit bounds keep X0+GLYPH_W from wrapping at the right edge of the screen.
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + GLYPH_W);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + GLYPH_H);

    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [9:0]  off_x;
    logic [9:0]  off_y;

    assign x_ext = {1'b0, draw_x};
    assign y_ext = {1'b0, draw_y};
    assign off_x = draw_x - X_LO[9:0];
    assign off_y = draw_y - Y_LO[9:0];

    assign hit  = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
    assign addr = ADDR_W'(off_x) + ADDR_W'(off_y) * ADDR_W'(GLYPH_W);

endmodule

// File: rtl/start_screen_overlay.sv
// Title-screen overlay: glyph hit/address pipeline plus the player-count selector.
//   state      | meaning
//   ST_IDLE    | not on the start screen; waits for game_state == 0
//   ST_SELECT  | prompts blinking, left/right choose players, enter confirms
//   ST_CONFIRM | selection latched, keys ignored until the game leaves the start screen
module start_screen_overlay
    import start_screen_overlay_pkg::*;
#(
    parameter int NUM_GLYPHS   = NUM_GLYPHS_DEF,
    parameter int GLYPH_W      = GLYPH_W_DEF,
    parameter int GLYPH_H      = GLYPH_H_DEF,
    parameter int ADDR_W       = 19,
    parameter int IDX_W        = 5,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_tick,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [1:0]        game_state,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              key_enter,
    output logic              is_starting,
    output logic [IDX_W-1:0]  starting_idx,
    output logic [ADDR_W-1:0] starting_read_address,
    output logic              player_sel,
    output logic              start_req
);

    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0] P1_IDX   = IDX_W'(NUM_GLYPHS - 2);

    logic [NUM_GLYPHS-1:0] hit_vec;
    logic [ADDR_W-1:0]     addr_arr [NUM_GLYPHS];

    for (genvar g = 0; g < NUM_GLYPHS; g++) begin : g_glyph
        glyph_hit #(
            .X0      (GLYPH_X[g]),
            .Y0      (GLYPH_Y[g]),
            .GLYPH_W (GLYPH_W),
            .GLYPH_H (GLYPH_H),
            .ADDR_W  (ADDR_W)
        ) u_glyph_hit (
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (hit_vec[g]),
            .addr   (addr_arr[g])
        );
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              blink_on_q, blink_on_d;
    logic              player_sel_q, player_sel_d;
    logic              start_req_q, start_req_d;
    logic              is_starting_q, is_starting_d;
    logic [IDX_W-1:0]  starting_idx_q, starting_idx_d;
    logic [ADDR_W-1:0] read_addr_q, read_addr_d;

    logic             on_start;
    logic [IDX_W-1:0] blank_idx;

    assign on_start  = (game_state == 2'b00);
    assign blank_idx = P1_IDX + IDX_W'(player_sel_q);

    // Descending scan so the lowest-index hit is the one left standing.
    always_comb begin
        is_starting_d  = 1'b0;
        starting_idx_d = '0;
        read_addr_d    = '0;
        if (on_start) begin
            for (int g = NUM_GLYPHS - 1; g >= 0; g--) begin
                if (hit_vec[g] && !(!blink_on_q && (IDX_W'(g) == blank_idx))) begin
                    is_starting_d  = 1'b1;
                    starting_idx_d = IDX_W'(g);
                    read_addr_d    = addr_arr[g];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        blink_cnt_d  = blink_cnt_q;
        blink_on_d   = blink_on_q;
        player_sel_d = player_sel_q;
        start_req_d  = 1'b0;

        if (on_start && frame_tick) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (on_start) begin
                    state_d     = ST_SELECT;
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end
            end
            ST_SELECT: begin
                if (!on_start) begin
                    state_d = ST_IDLE;
                end else begin
                    // Direction is applied before enter so a combined press confirms the new choice.
                    if (key_left) begin
                        player_sel_d = 1'b0;
                    end else if (key_right) begin
                        player_sel_d = 1'b1;
                    end
                    if (key_enter) begin
                        state_d     = ST_CONFIRM;
                        start_req_d = 1'b1;
                    end
                end
            end
            ST_CONFIRM: begin
                if (!on_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q        <= ST_IDLE;
            blink_cnt_q    <= '0;
            blink_on_q     <= 1'b1;
            player_sel_q   <= 1'b0;
            start_req_q    <= 1'b0;
            is_starting_q  <= 1'b0;
            starting_idx_q <= '0;
            read_addr_q    <= '0;
        end else begin
            state_q        <= state_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_on_q     <= blink_on_d;
            player_sel_q   <= player_sel_d;
            start_req_q    <= start_req_d;
            is_starting_q  <= is_starting_d;
            starting_idx_q <= starting_idx_d;
            read_addr_q    <= read_addr_d;
        end
    end

    assign is_starting           = is_starting_q;
    assign starting_idx          = starting_idx_q;
    assign starting_read_address = read_addr_q;
    assign player_sel            = player_sel_q;
    assign start_req             = start_req_q;

endmodule

// File: doc/start_screen_overlay.md
START_SCREEN_OVERLAY -- requirements
Module: start_screen_overlay

Interface
REQ-001 Parameter NUM_GLYPHS, default 9: number of title-screen glyph slots; indices 0..NUM_GLYPHS-3 are title, the last two are player-1 and player-2 prompts.
REQ-002 Parameter GLYPH_W, default 30: glyph width in pixels.
REQ-003 Parameter GLYPH_H, default 45: glyph height in pixels.
REQ-004 Parameter ADDR_W, default 19: width of the sprite ROM read address.
REQ-005 Parameter IDX_W, default 5: width of the glyph index output.
REQ-006 Parameter BLINK_FRAMES, default 30: frames per blink half-period of the selected prompt.
REQ-007 Clk  input  1  system clock; the only clock.
REQ-008 Reset_n  input  1  reset, synchronous, active-low.
REQ-009 frame_tick  input  1  one-Clk pulse per video frame.
REQ-010 DrawX, DrawY  input  10 each  current pixel coordinates.
REQ-011 game_state  input  2  global game state; 2'b00 = start screen.
REQ-012 key_left, key_right, key_enter  input  1 each  one-Clk key-press pulses.
REQ-013 is_starting  output  1  glyph pixel hit, registered.
REQ-014 starting_idx  output  IDX_W  index of the hit glyph, registered.
REQ-015 starting_read_address  output  ADDR_W  ROM address within the glyph, registered.
REQ-016 player_sel  output  1  0 = one player, 1 = two players.
REQ-017 start_req  output  1  one-Clk pulse when the selection is confirmed.

Function
REQ-018 Hit test per glyph g: DrawX >= X[g] and DrawX < X[g]+GLYPH_W and DrawY >= Y[g] and DrawY < Y[g]+GLYPH_H; unsigned, half-open bounds.
REQ-019 Multiple hits resolve to the lowest index.
REQ-020 Address = (DrawX-X[g]) + (DrawY-Y[g])*GLYPH_W, computed at ADDR_W bits with no truncation below GLYPH_W*GLYPH_H-1.
REQ-021 Hit, index and address are registered; each appears exactly 1 Clk after its DrawX/DrawY sample.
REQ-022 No hit, game_state != 2'b00, or blanked prompt -> next-cycle is_starting=0, starting_idx=0, starting_read_address=0.
REQ-023 Blink counter counts frame_tick; phase toggles every BLINK_FRAMES ticks; counter and phase hold while game_state != 2'b00.
REQ-024 Prompt glyph for the current player_sel is blanked during the off phase; the other prompt and title glyphs are always shown.
REQ-025 FSM states: IDLE, SELECT, CONFIRM.
REQ-026 IDLE -> SELECT when game_state == 2'b00; on entry, blink phase = on and counter = 0.
REQ-027 SELECT: key_left sets player_sel=0; key_right sets player_sel=1; key_enter -> CONFIRM and start_req=1 for that cycle.
REQ-028 Simultaneous key_enter with key_left/right: the direction key applies first; the confirmed selection is the updated value.
REQ-029 CONFIRM: keys ignored, start_req=0; -> IDLE when game_state != 2'b00.
REQ-030 Any state: game_state != 2'b00 forces IDLE except CONFIRM (REQ-029); player_sel holds its last value.

Reset
REQ-031 Reset_n low at a Clk edge: FSM=IDLE, blink counter=0, phase=on, player_sel=0, start_req=0, is_starting=0, starting_idx=0, starting_read_address=0.
REQ-032 Reset mid-CONFIRM or mid-blink discards state and issues no start_req.

Structure
REQ-033 A shared package holds the glyph X/Y position constant arrays (title at x=200,230,290,320,350,380,410 with y=165; P1 (260,270); P2 (350,270)), the FSM state typedef and the default glyph size constants.
REQ-034 One sub-module, glyph_hit, performs the single-glyph bounds test and offset address; it is instantiated NUM_GLYPHS times via generate.

Verification
REQ-035 game_state=0, (DrawX,DrawY)=(200,165) -> next cycle is_starting=1, idx=0, addr=0; (229,209) -> idx=0, addr=1349.
REQ-036 (230,165) -> idx=1, addr=0 (half-open bound); game_state=1 at (200,165) -> is_starting=0.
REQ-037 player_sel=0, SELECT, 30 frame_ticks, pixel (260,270) -> is_starting=0; after 30 more -> is_starting=1; (350,270) always 1 with idx=8.
REQ-038 SELECT, key_right then key_enter -> player_sel=1, start_req high for exactly 1 Clk; later key_left in CONFIRM -> player_sel stays 1.
REQ-039 Reset_n low in CONFIRM with pixel on a glyph -> next cycle all outputs 0, FSM=IDLE, no start_req.
